// File: rtl/pulse_period_meter.sv
// Pulse train period meter: synchronised rise-to-rise timing with lock and timeout.
// Define PULSE_PERIOD_METER_DUTY_EN to also measure high time per period.
module pulse_period_meter #(
    parameter int WIDTH          = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             enable,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);
    localparam logic [WIDTH-1:0] TC  = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_prev_q;
    logic                   rise;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            s_prev_q  <= s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        if (!enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            period_d  = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    // the re-arming rise after a timeout clears the flag
                    if (rise) begin
                        cnt_d     = ONE;
                        timeout_d = 1'b0;
                        state_d   = MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        locked_d  = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = ONE;
                    end else if (cnt_q == TC) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;

`ifdef PULSE_PERIOD_METER_DUTY_EN
    logic             fall;
    logic             meas_rise;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             fall_seen_q, fall_seen_d;

    assign fall      = ~s & s_prev_q;
    assign meas_rise = enable & rise & (state_q == MEAS);

    always_comb begin
        hcnt_d      = hcnt_q;
        hold_d      = hold_q;
        fall_seen_d = fall_seen_q;
        high_d      = high_q;
        // saturate so a stuck-high input cannot wrap the counter
        if (rise) begin
            hcnt_d      = ONE;
            fall_seen_d = 1'b0;
        end else if (s && hcnt_q != TC) begin
            hcnt_d = hcnt_q + ONE;
        end
        if (fall) begin
            hold_d      = hcnt_q;
            fall_seen_d = 1'b1;
        end
        if (!enable) begin
            high_d = '0;
        end else if (meas_rise) begin
            high_d = fall_seen_q ? hold_q : cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q      <= '0;
            hold_q      <= '0;
            high_q      <= '0;
            fall_seen_q <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            hold_q      <= hold_d;
            high_q      <= high_d;
            fall_seen_q <= fall_seen_d;
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomised scoreboard bench for pulse_period_meter.
// Reference model works from synced rise/fall times and enable/reset history.
module tb_pulse_period_meter;
    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TO = 100;
    localparam int N  = 20000;
`ifdef PULSE_PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         pulse_in;
    logic         enable;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         locked;
    logic         timeout;

    pulse_period_meter #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pulse_in(pulse_in),
        .enable(enable),
        .period(period),
        .high_time(high_time),
        .valid(valid),
        .locked(locked),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int per;
        int hi;
    } ev_t;

    ev_t q[$];

    bit p_h[N];
    bit e_h[N];
    bit r_h[N];
    int xp_per[N];
    int xp_hi[N];
    bit xp_lk[N];
    bit xp_to[N];

    int cyc = 0;
    bit run = 1'b0;
    bit en_cur = 1'b0;
    bit in_rst = 1'b0;
    int tests = 0;
    int fails = 0;

    int last = -1;
    int rise_h = 0;
    int hold = 0;
    bit fall_seen = 1'b0;
    int cur_per = 0;
    int cur_hi = 0;
    bit cur_lk = 1'b0;
    bit cur_to = 1'b0;

    function automatic bit sv(input int c);
        return (c >= S) ? p_h[c-S] : 1'b0;
    endfunction

    function automatic bit live(input int c);
        return (c >= 0) ? (e_h[c] && !r_h[c]) : 1'b0;
    endfunction

    // expected outputs visible in cycle n+1, from events seen in cycle n
    task automatic model(input int n);
        bit rise;
        bit fall;
        rise = sv(n) && !sv(n-1);
        fall = !sv(n) && sv(n-1);
        if (!live(n)) begin
            last    = -1;
            cur_per = 0;
            cur_hi  = 0;
            cur_lk  = 1'b0;
            cur_to  = 1'b0;
        end else if (!live(n-1)) begin
            last = -1;
        end else if (rise) begin
            if (last >= 0) begin
                cur_per = n - last;
                cur_hi  = DUTY ? (fall_seen ? hold : cur_per) : 0;
                cur_lk  = 1'b1;
                q.push_back('{n + 1, cur_per, cur_hi});
            end
            cur_to = 1'b0;
            last   = n;
        end else if (last >= 0 && n - last == TO) begin
            cur_to = 1'b1;
            cur_lk = 1'b0;
            last   = -1;
        end
        if (rise) begin
            rise_h    = n;
            fall_seen = 1'b0;
        end
        if (fall) begin
            hold      = n - rise_h;
            fall_seen = 1'b1;
        end
        xp_per[n+1] = cur_per;
        xp_hi[n+1]  = cur_hi;
        xp_lk[n+1]  = cur_lk;
        xp_to[n+1]  = cur_to;
    endtask

    task automatic tick(input bit pin);
        @(posedge clk);
        #1;
        cyc++;
        pulse_in = pin;
        enable   = en_cur;
        p_h[cyc] = in_rst ? 1'b0 : pin;
        e_h[cyc] = en_cur;
        r_h[cyc] = in_rst;
        model(cyc);
    endtask

    task automatic wave(input int h, input int l, input int k);
        repeat (k) begin
            repeat (h) tick(1'b1);
            repeat (l) tick(1'b0);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({period, high_time, valid, locked, timeout} !== '0) begin
            fails++;
            $display("FAIL %s: got per=%0d hi=%0d v=%0b lk=%0b to=%0b want all 0",
                     name, period, high_time, valid, locked, timeout);
        end
    endtask

    // async reset in the middle of a cycle, held a few cycles
    task automatic reset_pulse();
        tick(1'b1);
        #2;
        reset = 1'b1;
        r_h[cyc] = 1'b1;
        for (int k = cyc - 2; k <= cyc; k++) p_h[k] = 1'b0;
        while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
        last = -1; cur_per = 0; cur_hi = 0; cur_lk = 0; cur_to = 0;
        hold = 0; fall_seen = 0;
        xp_per[cyc] = 0; xp_hi[cyc] = 0; xp_lk[cyc] = 0; xp_to[cyc] = 0;
        xp_per[cyc+1] = 0; xp_hi[cyc+1] = 0; xp_lk[cyc+1] = 0; xp_to[cyc+1] = 0;
        #1;
        check_zero("async_reset");
        in_rst = 1'b1;
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        in_rst = 1'b0;
        tick(1'b0);
        #2;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (run) begin
            tests++;
            if (period !== xp_per[cyc] || high_time !== xp_hi[cyc] ||
                locked !== xp_lk[cyc] || timeout !== xp_to[cyc]) begin
                fails++;
                $display("FAIL status cyc=%0d got per=%0d hi=%0d lk=%0b to=%0b want per=%0d hi=%0d lk=%0b to=%0b",
                         cyc, period, high_time, locked, timeout,
                         xp_per[cyc], xp_hi[cyc], xp_lk[cyc], xp_to[cyc]);
            end
            tests++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                if (valid !== 1'b1 || period !== q[0].per || high_time !== q[0].hi) begin
                    fails++;
                    $display("FAIL strobe cyc=%0d got v=%0b per=%0d hi=%0d want v=1 per=%0d hi=%0d",
                             cyc, valid, period, high_time, q[0].per, q[0].hi);
                end
                void'(q.pop_front());
            end else if (valid !== 1'b0) begin
                fails++;
                $display("FAIL spurious_valid cyc=%0d got v=%0b want v=0", cyc, valid);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        pulse_in = 1'b0;
        enable   = 1'b0;
        #7;
        check_zero("reset_state");
        #5;
        reset = 1'b0;
        run   = 1'b1;

        en_cur = 1'b1;
        repeat (3) tick(1'b0);
        wave(2, 2, 10);
        wave(1, 1, 15);
        wave(3, 3, 6);
        repeat (150) tick(1'b0);
        wave(4, 4, 6);
        wave(3, 3, 6);
        wave(5, 5, 6);
        wave(4, 4, 5);
        reset_pulse();
        wave(4, 4, 5);
        wave(5, 5, 3);
        wave(2, 0, 1);
        en_cur = 1'b0;
        tick(1'b1);
        en_cur = 1'b1;
        wave(2, 5, 1);
        wave(5, 5, 4);
        wave(50, 50, 4);
        wave(50, 51, 3);
        wave(120, 10, 2);
        wave(3, 4, 4);

        while (cyc < 9000) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                en_cur = 1'b0;
                tick(1'($urandom_range(0, 1)));
                en_cur = 1'b1;
            end else if (r == 1) begin
                repeat ($urandom_range(90, 130)) tick(1'b0);
            end else if (r == 2) begin
                reset_pulse();
            end else begin
                wave(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
                     int'($urandom_range(1, 6)));
            end
        end

        repeat (6) tick(1'b0);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d strobes outstanding want 0", q.size());
        end
        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
